// File: rtl/data_memory_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_ctrl_if
// Description : Request/response bundle between the MEM stage and the data
//               memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_memory_ctrl_if #(
    parameter int DW = 16,
    parameter int AW = 16
);
    logic          req;
    logic          we;
    logic          size;
    logic          sext;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ready;
    logic          done;
    logic [DW-1:0] rdata;
    logic          err;

    modport master (
        output req, we, size, sext, addr, wdata,
        input  ready, done, rdata, err
    );

    modport slave (
        input  req, we, size, sext, addr, wdata,
        output ready, done, rdata, err
    );
endinterface
`default_nettype wire

// File: rtl/data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_ctrl
// Description : Handshaked big-endian byte/word data memory with programmable
//               wait states. Define DMEM_ERR_CHECK_EN for alignment/range errors.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_ctrl #(
    parameter int DW    = 16,
    parameter int AW    = 16,
    parameter int DEPTH = 256,
    parameter int WAIT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    data_memory_ctrl_if.slave bus
);

    localparam int             c_NB      = DW / 8;
    localparam int             c_IW      = $clog2(DEPTH);
    localparam logic [3:0]     c_WAIT_LD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_ready;
    logic              w_done;
    logic              w_transfer;

    logic [3:0]        r_cnt;
    logic              r_we;
    logic              r_size;
    logic              r_sext;
    logic [AW-1:0]     r_addr;
    logic [DW-1:0]     r_wdata;
    logic [DW-1:0]     r_rdata;
    logic              r_err;

    logic [7:0]        r_mem [DEPTH];

    logic [AW-1:0]     w_first_addr;
    logic [c_IW-1:0]   w_idx0;
    logic [DW-1:0]     w_rd_word;
    logic [7:0]        w_byte;
    logic [DW-1:0]     w_load_val;
    logic              w_err_det;
    logic              w_commit;
    logic              w_unused;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.req) begin
                    w_state_nxt = (WAIT > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_transfer = w_ready && bus.req;

    // Wait counter is preloaded on transfer so it reads WAIT-1 in the first wait cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 4'd0;
        end else if (w_transfer) begin
            r_cnt <= c_WAIT_LD;
        end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we    <= 1'b0;
            r_size  <= 1'b0;
            r_sext  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_transfer) begin
            r_we    <= bus.we;
            r_size  <= bus.size;
            r_sext  <= bus.sext;
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
        end
    end

    // ------------------------------------------------------------------
    // Address decode and error detection
    // ------------------------------------------------------------------
`ifdef DMEM_ERR_CHECK_EN
    logic          w_misalign;
    logic [AW:0]   w_last_addr;

    assign w_first_addr = r_addr;
    assign w_misalign   = r_size && ((r_addr % AW'(c_NB)) != '0);
    // One extra bit so the end-of-access address cannot overflow back into range
    assign w_last_addr  = {1'b0, r_addr} + (AW+1)'(r_size ? (c_NB - 1) : 0);
    assign w_err_det    = w_misalign || (w_last_addr >= (AW+1)'(DEPTH));
`else
    assign w_first_addr = r_size ? (r_addr - (r_addr % AW'(c_NB))) : r_addr;
    assign w_err_det    = 1'b0;
`endif

    assign w_idx0   = w_first_addr[c_IW-1:0];
    assign w_unused = ^w_first_addr;

    // Lane k holds byte addr+k; lane 0 lands in the most significant byte
    for (genvar k = 0; k < c_NB; k++) begin : g_lane
        logic [c_IW-1:0] w_idx;
        assign w_idx                     = w_idx0 + c_IW'(k);
        assign w_rd_word[DW-1-8*k -: 8]  = r_mem[w_idx];
    end

    assign w_byte     = w_rd_word[DW-1 -: 8];
    assign w_load_val = r_size ? w_rd_word
                               : {{(DW-8){r_sext & w_byte[7]}}, w_byte};

    // ------------------------------------------------------------------
    // Storage and result registers
    // ------------------------------------------------------------------
    assign w_commit = (r_state == S_ACCESS) && r_we && !w_err_det;

    // Gated on rst so a store whose closing edge meets reset assertion is dropped
    always_ff @(posedge clk) begin
        if (w_commit && rst) begin
            if (r_size) begin
                for (int k = 0; k < c_NB; k++) begin
                    r_mem[w_idx0 + c_IW'(k)] <= r_wdata[DW-1-8*k -: 8];
                end
            end else begin
                r_mem[w_idx0] <= r_wdata[7:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (r_state == S_ACCESS) begin
            r_err <= w_err_det;
            if (w_err_det) begin
                r_rdata <= '0;
            end else if (!r_we) begin
                r_rdata <= w_load_val;
            end
        end
    end

    assign bus.ready = w_ready;
    assign bus.done  = w_done;
    assign bus.rdata = r_rdata;
    assign bus.err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory_ctrl
// Description : Directed + random bench for data_memory_ctrl against a byte-array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 256;
    localparam int WA    = 2;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    data_memory_ctrl_if #(.DW(DW), .AW(AW)) ia ();
    data_memory_ctrl_if #(.DW(DW), .AW(AW)) ib ();

    data_memory_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .WAIT(WA)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ia)
    );

    data_memory_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .WAIT(0)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model: plain byte array, addressing rules computed arithmetically
    logic [7:0]  mem [DEPTH];
    logic [15:0] last_rd;

    function automatic bit m_err(input bit s, input int a);
`ifdef DMEM_ERR_CHECK_EN
        return (s && (a % 2 != 0)) || (a + (s ? 1 : 0) >= DEPTH);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int m_base(input bit s, input int a);
`ifdef DMEM_ERR_CHECK_EN
        return a;
`else
        if (s) return (a - a % 2) % DEPTH;
        return a % DEPTH;
`endif
    endfunction

    function automatic logic [15:0] m_load(input bit s, input bit sx, input int a);
        int b;
        b = m_base(s, a);
        if (s) return {mem[b], mem[b+1]};
        if (sx) return {{8{mem[b][7]}}, mem[b]};
        return {8'h00, mem[b]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic acc(input bit w, input bit s, input bit sx, input int a,
                       input logic [15:0] d, input bit hold,
                       output logic [15:0] rd, output logic e);
        int n;
        n = 0;
        while (ia.ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("idle_ready", 32'(ia.ready), 32'd1);
        ia.req   = 1'b1;
        ia.we    = w;
        ia.size  = s;
        ia.sext  = sx;
        ia.addr  = a[15:0];
        ia.wdata = d;
        @(posedge clk);
        @(negedge clk);
        // Post-transfer inputs are don't-care: scramble them
        ia.req   = hold;
        ia.we    = 1'($urandom);
        ia.size  = 1'($urandom);
        ia.sext  = 1'($urandom);
        ia.addr  = 16'($urandom);
        ia.wdata = 16'($urandom);
        n = 1;
        while (ia.done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(WA + 2));
        rd = ia.rdata;
        e  = ia.err;
        ia.req = 1'b0;
        @(negedge clk);
        chk("ready_back", 32'(ia.ready), 32'd1);
        chk("done_pulse", 32'(ia.done), 32'd0);
    endtask

    task automatic op(input string tag, input bit w, input bit s, input bit sx,
                      input int a, input logic [15:0] d, input bit hold,
                      output logic [15:0] rd);
        logic [15:0] exp_rd;
        logic        e;
        bit          exp_e;
        exp_e = m_err(s, a);
        acc(w, s, sx, a, d, hold, rd, e);
        chk({tag, "_err"}, 32'(e), 32'(exp_e));
        if (exp_e)  exp_rd = 16'h0000;
        else if (w) exp_rd = last_rd;
        else        exp_rd = m_load(s, sx, a);
        chk({tag, "_rdata"}, 32'(rd), 32'(exp_rd));
        last_rd = exp_rd;
        if (w && !exp_e) begin
            if (s) begin
                mem[m_base(s, a)]     = d[15:8];
                mem[m_base(s, a) + 1] = d[7:0];
            end else begin
                mem[m_base(s, a)] = d[7:0];
            end
        end
    endtask

    initial begin
        logic [15:0] rd;
        logic [15:0] bw [3];
        int          xfer;
        int          dn;
        int          last;
        int          cnt;

        total   = 0;
        bad     = 0;
        last_rd = 16'h0000;
        rst     = 1'b0;
        ia.req = 1'b0; ia.we = 1'b0; ia.size = 1'b0; ia.sext = 1'b0; ia.addr = '0; ia.wdata = '0;
        ib.req = 1'b0; ib.we = 1'b0; ib.size = 1'b0; ib.sext = 1'b0; ib.addr = '0; ib.wdata = '0;

        repeat (3) @(negedge clk);
        chk("rst_done",  32'(ia.done),  32'd0);
        chk("rst_rdata", 32'(ia.rdata), 32'd0);
        chk("rst_err",   32'(ia.err),   32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(ia.ready), 32'd1);

        // Fill storage so every later load has a defined expectation
        for (int i = 0; i < DEPTH / 2; i++) begin
            op("fill", 1'b1, 1'b1, 1'b0, 2 * i, 16'($urandom), 1'b0, rd);
        end

        op("st_w0",  1'b1, 1'b1, 1'b0, 0, 16'h3CAD, 1'b0, rd);
        op("ld_w0",  1'b0, 1'b1, 1'b0, 0, 16'h0000, 1'b0, rd);
        chk("ld_w0_const", 32'(rd), 32'h3CAD);
        op("ld_b1",  1'b0, 1'b0, 1'b0, 1, 16'h0000, 1'b0, rd);
        chk("ld_b1_const", 32'(rd), 32'h00AD);

        op("st_b5",  1'b1, 1'b0, 1'b0, 5, 16'h1280, 1'b0, rd);
        op("ld_b5s", 1'b0, 1'b0, 1'b1, 5, 16'h0000, 1'b0, rd);
        chk("ld_b5s_const", 32'(rd), 32'hFF80);
        op("ld_b5z", 1'b0, 1'b0, 1'b0, 5, 16'h0000, 1'b0, rd);
        chk("ld_b5z_const", 32'(rd), 32'h0080);
        op("ld_w4",  1'b0, 1'b1, 1'b0, 4, 16'h0000, 1'b0, rd);
        chk("ld_w4_lo", 32'(rd[7:0]), 32'h80);

        // Misaligned / out-of-range word accesses (error or wrap, build dependent)
        op("st_w3",  1'b1, 1'b1, 1'b0, 3, 16'hBEEF, 1'b0, rd);
        op("ld_w2",  1'b0, 1'b1, 1'b0, 2, 16'h0000, 1'b0, rd);
        op("ld_w4b", 1'b0, 1'b1, 1'b0, 4, 16'h0000, 1'b0, rd);
        op("ld_w3",  1'b0, 1'b1, 1'b0, 3, 16'h0000, 1'b0, rd);
        op("ld_wtop", 1'b0, 1'b1, 1'b0, DEPTH - 1, 16'h0000, 1'b0, rd);
        op("ld_wrap", 1'b0, 1'b1, 1'b0, DEPTH + 4, 16'h0000, 1'b0, rd);

        for (int i = 0; i < 40; i++) begin
            op("rnd", 1'($urandom), 1'($urandom), 1'($urandom),
               int'($urandom_range(0, 300)), 16'($urandom), 1'b0, rd);
        end

        // req held through WAIT/ACCESS/DONE must not start a second access
        op("hold", 1'b0, 1'b1, 1'b0, 8, 16'h0000, 1'b1, rd);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ia.done === 1'b1) cnt++;
        end
        chk("hold_extra_done", 32'(cnt), 32'd0);

        // Reset during WAIT of a store
        op("st_daed", 1'b1, 1'b1, 1'b0, 4, 16'hDAED, 1'b0, rd);
        ia.req = 1'b1; ia.we = 1'b1; ia.size = 1'b1; ia.sext = 1'b0;
        ia.addr = 16'h0004; ia.wdata = 16'h1463;
        @(posedge clk);
        @(negedge clk);
        ia.req = 1'b0;
        chk("in_wait_ready", 32'(ia.ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("arst_ready", 32'(ia.ready), 32'd1);
        chk("arst_done",  32'(ia.done),  32'd0);
        chk("arst_rdata", 32'(ia.rdata), 32'd0);
        chk("arst_err",   32'(ia.err),   32'd0);
        @(negedge clk);
        rst = 1'b1;
        last_rd = 16'h0000;
        @(negedge clk);
        chk("arst_ready_rel", 32'(ia.ready), 32'd1);
        op("ld_after_rst", 1'b0, 1'b1, 1'b0, 4, 16'h0000, 1'b0, rd);
        chk("ld_after_rst_const", 32'(rd), 32'hDAED);

        // WAIT=0 instance: back-to-back with req held high
        for (int i = 0; i < 3; i++) bw[i] = 16'($urandom);
        xfer = 0;
        dn   = 0;
        last = -1;
        for (int cyc = 0; cyc < 40 && dn < 6; cyc++) begin
            @(negedge clk);
            if (ib.done === 1'b1) begin
                if (dn >= 3) chk("b2b_load", 32'(ib.rdata), 32'(bw[dn-3]));
                dn++;
            end
            if (ib.ready === 1'b1) begin
                if (last >= 0) chk("b2b_gap", 32'(cyc - last), 32'd3);
                last = cyc;
                if (xfer < 6) begin
                    ib.req   = 1'b1;
                    ib.we    = (xfer < 3);
                    ib.size  = 1'b1;
                    ib.sext  = 1'b0;
                    ib.addr  = 16'(16'h20 + 2 * (xfer % 3));
                    ib.wdata = (xfer < 3) ? bw[xfer] : 16'h0000;
                    xfer++;
                end else begin
                    ib.req = 1'b0;
                end
            end
        end
        ib.req = 1'b0;
        chk("b2b_xfers", 32'(xfer), 32'd6);
        chk("b2b_dones", 32'(dn), 32'd6);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ib.done === 1'b1) cnt++;
        end
        chk("b2b_extra_done", 32'(cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
